// File: rtl/fft32_pkg.sv
// rtl/fft32_pkg.sv - shared types and width helpers for the round/saturate pipeline
// Purpose: rounding-mode encoding and the intermediate-width helper used by
//          round_sat_pipe and round_sat_lane.
// Ports:   none (package).
package fft32_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'b00,
    RND_HALF_UP   = 2'b01,
    RND_HALF_EVEN = 2'b10,
    RND_RSVD      = 2'b11
  } round_mode_e;

  // Width of the rounded intermediate: one guard bit over the input so the
  // rounding bias cannot overflow, plus room for a left shift when the
  // output has more fractional bits than the input.
  function automatic int rnd_width(input int wi, input int d);
    return wi + 1 + ((d < 0) ? -d : 0);
  endfunction

endpackage

// File: rtl/round_sat_pipe_if.sv
// rtl/round_sat_pipe_if.sv - input/output beat streams of the round/saturate pipeline
// Purpose: bundles the input beat (valid/ready/data/mode) and the output beat
//          (valid/ready/data/sat) handshakes.
// Ports:   master = upstream/downstream side, slave = the pipeline.
//          WI = per-channel input width, WO = per-channel output width.
interface round_sat_pipe_if #(
  parameter int NCH = 2,
  parameter int WI  = 6,
  parameter int WO  = 11
);
  logic               in_valid;
  logic               in_ready;
  logic [NCH*WI-1:0]  in_data;
  logic [1:0]         round_mode;
  logic               out_valid;
  logic               out_ready;
  logic [NCH*WO-1:0]  out_data;
  logic [NCH-1:0]     out_sat;

  modport master (
    output in_valid, in_data, round_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, round_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/round_sat_lane.sv
// rtl/round_sat_lane.sv - per-channel combinational round and saturate
// Purpose: round S(I1,F1) to F2 fractional bits, then clamp to S(I2,F2).
//          The two halves are separate so the parent can register between them.
// Ports:   x/mode -> rnd   : rounding half (feeds stage 1 register)
//          rnd_q  -> y/sat : saturation half (feeds stage 2 register)
module round_sat_lane
  import fft32_pkg::*;
#(
  parameter int I1 = 0,
  parameter int F1 = 5,
  parameter int I2 = 8,
  parameter int F2 = 2,
  localparam int WI = I1 + F1 + 1,
  localparam int WO = I2 + F2 + 1,
  localparam int WR = rnd_width(WI, F1 - F2)
) (
  input  logic signed [WI-1:0] x,
  input  round_mode_e          mode,
  output logic signed [WR-1:0] rnd,
  input  logic signed [WR-1:0] rnd_q,
  output logic signed [WO-1:0] y,
  output logic                 sat
);

  localparam int D  = F1 - F2;
  // DP keeps bit selects and shift amounts legal when no rounding occurs.
  localparam int DP = (D > 0) ? D : 1;
  localparam int SH = (D < 0) ? -D : 0;
  localparam int WC = ((WR > WO) ? WR : WO) + 1;

  function automatic logic signed [WR-1:0] round_fn(input logic signed [WI-1:0] v,
                                                    input round_mode_e m);
    logic signed [WR-1:0] ve;
    logic signed [WR-1:0] bias;
    ve = {{(WR-WI){v[WI-1]}}, v};
    if (D <= 0) return ve <<< SH;
    case (m)
      RND_TRUNC:     bias = '0;
      // tie goes up only when the retained LSB is odd
      RND_HALF_EVEN: bias = (WR'(1) <<< (DP-1)) - WR'(1) + WR'(v[DP]);
      default:       bias = WR'(1) <<< (DP-1);
    endcase
    return (ve + bias) >>> DP;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [WO:0] sat_fn(input logic signed [WR-1:0] r);
    logic signed [WC-1:0] re;
    logic signed [WC-1:0] hi;
    logic signed [WC-1:0] lo;
    re = {{(WC-WR){r[WR-1]}}, r};
    hi = (WC'(1) <<< (WO-1)) - WC'(1);
    lo = -(WC'(1) <<< (WO-1));
    if (re > hi)      return {1'b1, hi[WO-1:0]};
    else if (re < lo) return {1'b1, lo[WO-1:0]};
    else              return {1'b0, re[WO-1:0]};
  endfunction

  logic [WO:0] sv;

  assign rnd = round_fn(x, mode);
  assign sv  = sat_fn(rnd_q);
  assign sat = sv[WO];
  assign y   = sv[WO-1:0];

endmodule

// File: rtl/round_sat_pipe.sv
// rtl/round_sat_pipe.sv - two-stage round/saturate pipeline with saturation counters
// Purpose: S1 registers rounded samples, S2 registers saturated results; a
//          single stall enable moves both stages together.
// Ports:   clk, rst_n (async active-low); bus (slave stream: in_* / out_*);
//          clear_cnt clears sat_count/sat_sticky; sat_sticky per-channel OR of
//          out_sat over transfers; sat_count saturating count of sat transfers.
module round_sat_pipe
  import fft32_pkg::*;
#(
  parameter int I1    = 0,
  parameter int F1    = 5,
  parameter int I2    = 8,
  parameter int F2    = 2,
  parameter int NCH   = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  round_sat_pipe_if.slave      bus,
  input  logic                 clear_cnt,
  output logic [NCH-1:0]       sat_sticky,
  output logic [CNT_W-1:0]     sat_count
);

  localparam int WI = I1 + F1 + 1;
  localparam int WO = I2 + F2 + 1;
  localparam int WR = rnd_width(WI, F1 - F2);

  logic              en;
  logic              xfer;
  logic              v1;
  logic              v2;
  logic [NCH*WR-1:0] rnd_d;
  logic [NCH*WR-1:0] rnd_q;
  logic [NCH*WO-1:0] y_d;
  logic [NCH*WO-1:0] od_q;
  logic [NCH-1:0]    sat_d;
  logic [NCH-1:0]    os_q;

  // One global enable: the whole pipe stalls only when the output is blocked.
  assign en            = bus.out_ready || !v2;
  assign xfer          = v2 && bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v2;
  assign bus.out_data  = od_q;
  assign bus.out_sat   = os_q;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    round_sat_lane #(.I1(I1), .F1(F1), .I2(I2), .F2(F2)) u_lane (
      .x     (bus.in_data[c*WI +: WI]),
      .mode  (round_mode_e'(bus.round_mode)),
      .rnd   (rnd_d[c*WR +: WR]),
      .rnd_q (rnd_q[c*WR +: WR]),
      .y     (y_d[c*WO +: WO]),
      .sat   (sat_d[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      rnd_q <= '0;
      od_q  <= '0;
      os_q  <= '0;
    end else if (en) begin
      // bubbles propagate as bubbles; data registers only load real beats
      v1 <= bus.in_valid;
      v2 <= v1;
      if (bus.in_valid) rnd_q <= rnd_d;
      if (v1) begin
        od_q <= y_d;
        os_q <= sat_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count  <= '0;
      sat_sticky <= '0;
    end else if (clear_cnt) begin
      // clear wins over a transfer in the same cycle; that beat is dropped
      sat_count  <= '0;
      sat_sticky <= '0;
    end else if (xfer) begin
      sat_sticky <= sat_sticky | os_q;
      if (|os_q && (sat_count != {CNT_W{1'b1}})) sat_count <= sat_count + 1'b1;
    end
  end

endmodule
